// File: rtl/multi_one_shot_if.sv
// ----------------------------------------------------------------------------
// multi_one_shot_if
// Bundles the per-channel trigger/config inputs and the pulse/missed outputs
// of the multi-channel one-shot block.
//   master : drives trigger, edges, pulse_width, retrig_en, clr_missed;
//            observes pulse, missed, state_dbg
//   slave  : the one-shot block itself
// state_dbg[i] is 1 while channel i is in its ACTIVE state.
// ----------------------------------------------------------------------------
interface multi_one_shot_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0]   trigger;
    logic [2*NUM_CH-1:0] edges;
    logic [CNT_W-1:0]    pulse_width;
    logic [NUM_CH-1:0]   retrig_en;
    logic [NUM_CH-1:0]   clr_missed;
    logic [NUM_CH-1:0]   pulse;
    logic [NUM_CH-1:0]   missed;
    logic [NUM_CH-1:0]   state_dbg;

    modport master (
        output trigger, edges, pulse_width, retrig_en, clr_missed,
        input  pulse, missed, state_dbg
    );

    modport slave (
        input  trigger, edges, pulse_width, retrig_en, clr_missed,
        output pulse, missed, state_dbg
    );
endinterface

// File: rtl/multi_one_shot.sv
// ----------------------------------------------------------------------------
// multi_one_shot
// NUM_CH independent edge-triggered one-shot pulse generators.
//   clk  : system clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : multi_one_shot_if.slave
//          trigger[i]        channel trigger (already synchronous)
//          edges[2i+1:2i]    00 none, 01 falling, 10 rising, 11 both
//          pulse_width       shared pulse length, sampled at fire/reload
//          retrig_en[i]      edge during a pulse reloads instead of missing
//          clr_missed[i]     clears missed[i] (a simultaneous set wins)
//          pulse[i]          registered one-shot output
//          missed[i]         sticky: a qualifying edge was ignored
//          state_dbg[i]      1 while channel i is ACTIVE
// ----------------------------------------------------------------------------
module multi_one_shot #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    multi_one_shot_if.slave  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } ch_state_e;

    ch_state_e         state_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [NUM_CH-1:0] last_q;
    logic [NUM_CH-1:0] pulse_q;
    logic [NUM_CH-1:0] missed_q;
    logic [NUM_CH-1:0] edge_hit;

    // A qualifying edge compares the live trigger against last cycle's sample
    // and is masked by the channel's edge-select bits.
    always_comb begin
        edge_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            edge_hit[i] = ( bus.trigger[i] & ~last_q[i] & bus.edges[2*i+1]) |
                          (~bus.trigger[i] &  last_q[i] & bus.edges[2*i]);
        end
    end

    always_ff @(posedge clk) begin
        // The sample register tracks trigger unconditionally; loading it during
        // reset means a level held through reset is not seen as an edge.
        last_q <= bus.trigger;
        if (rst) begin
            pulse_q  <= '0;
            missed_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (state_q[i] == IDLE) begin
                    // W=0 fires nothing and is not a miss.
                    if (edge_hit[i] && (bus.pulse_width != '0)) begin
                        state_q[i] <= ACTIVE;
                        cnt_q[i]   <= bus.pulse_width;
                        pulse_q[i] <= 1'b1;
                    end
                end else begin
                    // The cnt=1 cycle is still ACTIVE, so an edge there reloads
                    // or misses rather than starting a fresh pulse.
                    if (edge_hit[i] && bus.retrig_en[i]) begin
                        if (bus.pulse_width != '0) begin
                            cnt_q[i] <= bus.pulse_width;
                        end else begin
                            state_q[i] <= IDLE;
                            cnt_q[i]   <= '0;
                            pulse_q[i] <= 1'b0;
                        end
                    end else if (cnt_q[i] == CNT_W'(1)) begin
                        state_q[i] <= IDLE;
                        cnt_q[i]   <= '0;
                        pulse_q[i] <= 1'b0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                    end
                end

                // Set has priority over clear.
                if (edge_hit[i] && (state_q[i] == ACTIVE) && !bus.retrig_en[i]) begin
                    missed_q[i] <= 1'b1;
                end else if (bus.clr_missed[i]) begin
                    missed_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.state_dbg = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.state_dbg[i] = (state_q[i] == ACTIVE);
        end
    end

    assign bus.pulse  = pulse_q;
    assign bus.missed = missed_q;

endmodule

// File: tb/tb_multi_one_shot.sv
// ----------------------------------------------------------------------------
// tb_multi_one_shot
// Drives inputs on the falling edge, steps a cycle-level reference model and
// queues the expected {state_dbg, missed, pulse}; a monitor pops and compares
// shortly after every rising edge.
// ----------------------------------------------------------------------------
module tb_multi_one_shot;

    localparam int NCH = 4;
    localparam int CW  = 4;
    localparam int EW  = 3 * NCH;

    logic clk = 1'b0;
    logic rst;

    multi_one_shot_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    multi_one_shot #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus state ----------------
    logic [NCH-1:0]   tr;
    logic [2*NCH-1:0] ed;
    logic [CW-1:0]    pw;
    logic [NCH-1:0]   re;
    logic [NCH-1:0]   cl;
    logic             rs;
    logic [NCH-1:0]   pulse_seen;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    // rem[i] = number of high pulse cycles still to come, starting next cycle.
    int rem    [NCH];
    bit mis_m  [NCH];
    bit last_m [NCH];

    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            bit rise;
            bit fall;
            bit hit;
            bit was_active;
            if (rs) begin
                rem[i]   = 0;
                mis_m[i] = 1'b0;
            end else begin
                rise       = tr[i] && !last_m[i];
                fall       = !tr[i] && last_m[i];
                hit        = (rise && ed[2*i+1]) || (fall && ed[2*i]);
                was_active = (rem[i] > 0);
                if (!was_active) begin
                    if (hit) rem[i] = int'(pw);
                end else if (hit && re[i]) begin
                    rem[i] = int'(pw);
                end else begin
                    rem[i] = rem[i] - 1;
                end
                if (hit && was_active && !re[i]) mis_m[i] = 1'b1;
                else if (cl[i])                  mis_m[i] = 1'b0;
            end
            last_m[i] = tr[i];
        end
    endtask

    function automatic logic [EW-1:0] model_out();
        logic [EW-1:0] e;
        e = '0;
        for (int i = 0; i < NCH; i++) begin
            e[i]         = (rem[i] > 0);
            e[NCH+i]     = mis_m[i];
            e[2*NCH+i]   = (rem[i] > 0);
        end
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clk);
        pulse_seen      = bus.pulse;
        bus.trigger     = tr;
        bus.edges       = ed;
        bus.pulse_width = pw;
        bus.retrig_en   = re;
        bus.clr_missed  = cl;
        rst             = rs;
        model_step();
        exp_q.push_back(model_out());
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] exp_v;
        logic [EW-1:0] act_v;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {bus.state_dbg, bus.missed, bus.pulse};
                n_checks++;
                if (act_v === exp_v) n_pass++;
                else $display("FAIL outputs t=%0t {state,missed,pulse} got %b expected %b",
                              $time, act_v, exp_v);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int hi_cnt;
        tr = '0; ed = '0; pw = '0; re = '0; cl = '0; rs = 1'b1;
        ticks(3);
        rs = 1'b0;
        ticks(2);

        // Ch0 rising, W=5: 5 high cycles, no miss.
        ed = 8'b00_00_00_10; pw = 4'd5;
        tr[0] = 1'b1; tick();
        ticks(8);
        tr[0] = 1'b0; ticks(2);

        // Ch1 both edges, W=3, retrigger on the fall two cycles later.
        ed = 8'b00_00_11_00; pw = 4'd3; re = 4'b0010;
        tr[1] = 1'b1; tick();
        tick();
        tr[1] = 1'b0; tick();
        ticks(6);

        // Ch2 falling only, no retrigger: second fall is missed.
        ed = 8'b00_01_00_00; pw = 4'd4; re = '0;
        tr[2] = 1'b1; ticks(2);
        tr[2] = 1'b0; tick();
        tr[2] = 1'b1; tick();
        tr[2] = 1'b0; tick();
        ticks(8);
        cl[2] = 1'b1; tick();
        cl[2] = 1'b0; ticks(2);

        // W=0 on all channels: nothing fires, nothing missed.
        ed = 8'b10_10_10_10; pw = 4'd0;
        tr = 4'hF; tick();
        ticks(3);
        tr = 4'h0; ticks(2);
        // W=2, simultaneous rises on ch0 and ch3.
        pw = 4'd2;
        tr = 4'b1001; tick();
        ticks(4);
        tr = 4'h0; ticks(2);

        // Trigger held high through reset: no pulse after release.
        tr = 4'hF; rs = 1'b1; ticks(3);
        rs = 1'b0; ticks(4);
        tr = 4'h0; ticks(2);

        // Reset in the middle of a W=8 pulse.
        ed = 8'b00_00_00_10; pw = 4'd8;
        tr[0] = 1'b1; tick();
        ticks(2);
        rs = 1'b1; tick();
        rs = 1'b0; ticks(3);
        tr[0] = 1'b0; ticks(2);

        // Maximum width with a 4-bit counter: exactly 15 cycles.
        pw = 4'd15;
        tr[0] = 1'b1; tick();
        pw = 4'd3;  // must not disturb the running count
        hi_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (pulse_seen[0]) hi_cnt++;
        end
        n_checks++;
        if (hi_cnt == 15) n_pass++;
        else $display("FAIL max_width high cycles got %0d expected 15", hi_cnt);
        tr[0] = 1'b0; ticks(2);

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 3) == 0) tr[i] = ~tr[i];
            end
            if ($urandom_range(0, 15) == 0) ed = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                pw = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) re = 4'($urandom);
            cl = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            rs = ($urandom_range(0, 79) == 0);
            tick();
        end
        rs = 1'b0; cl = '0;
        ticks(3);

        @(posedge clk);
        #4;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
